// File: rtl/tt_um_irrationalanalysis_prbs31_checker_if.sv
// Tile-side bus of the PRBS31 checker: enable, received byte, control byte and
// the readout/status outputs.
interface tt_um_irrationalanalysis_prbs31_checker_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_irrationalanalysis_prbs31_checker.sv
// Byte-parallel PRBS31 (x^31 + x^28 + 1) receive checker: self-seeds from the
// stream, then predicts each byte and counts bit errors with automatic lock loss.
module tt_um_irrationalanalysis_prbs31_checker #(
  parameter int LOSS_RUN = 4
) (
  input logic clk,
  input logic rst_n,
  tt_um_irrationalanalysis_prbs31_checker_if.slave bus
);

  // state  | meaning
  // SEED   | filling history from received bytes, no error counting
  // LOCKED | predicting each byte from history, counting mismatched bits
  typedef enum logic {SEED, LOCKED} state_t;

  localparam logic [2:0] LOSS_LIMIT = 3'(LOSS_RUN);

  state_t      state;
  logic [30:0] h;
  logic [1:0]  seed_cnt;
  logic [2:0]  bad_run;
  logic [15:0] err_cnt;
  logic [7:0]  err_mask;
  logic        err_pulse;

  logic        accept;
  logic        clr_cnt;
  logic [1:0]  sel;
  logic        locked;
  logic [30:0] h_seed;
  logic [30:0] h_walk;
  logic [7:0]  pred;
  logic [7:0]  mask;
  logic [3:0]  pop;
  logic [16:0] err_sum;
  logic [15:0] err_sat;
  logic [2:0]  bad_next;
  logic        unused;

  assign accept   = bus.uio_in[0] & bus.ena;
  assign sel      = bus.uio_in[2:1];
  assign clr_cnt  = bus.uio_in[3];
  assign unused   = &{1'b0, bus.uio_in[7:4]};
  assign locked   = (state == LOCKED);
  assign h_seed   = {h[22:0], bus.ui_in};
  assign bad_next = bad_run + 3'd1;

  // Serial 8-step walk of the recurrence; the first generated bit lands in bit 7.
  always_comb begin
    h_walk = h;
    pred   = '0;
    for (int i = 0; i < 8; i++) begin
      pred[7-i] = h_walk[30] ^ h_walk[27];
      h_walk    = {h_walk[29:0], h_walk[30] ^ h_walk[27]};
    end
  end

  assign mask = bus.ui_in ^ pred;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'd0, mask[i]};
    end
  end

  assign err_sum = {1'b0, err_cnt} + {13'd0, pop};
  assign err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= SEED;
      h         <= '0;
      seed_cnt  <= '0;
      bad_run   <= '0;
      err_cnt   <= '0;
      err_mask  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (accept) begin
        case (state)
          SEED: begin
            h        <= h_seed;
            seed_cnt <= seed_cnt + 2'd1;
            if (seed_cnt == 2'd3 && h_seed != '0) begin
              state <= LOCKED;
            end
          end
          LOCKED: begin
            // History follows the prediction so corrupted bits never reseed it.
            h        <= h_walk;
            err_mask <= mask;
            err_cnt  <= err_sat;
            if (mask != '0) begin
              err_pulse <= 1'b1;
              if (bad_next == LOSS_LIMIT) begin
                state    <= SEED;
                seed_cnt <= '0;
                bad_run  <= '0;
              end else begin
                bad_run <= bad_next;
              end
            end else begin
              bad_run <= '0;
            end
          end
          default: state <= SEED;
        endcase
      end
      if (clr_cnt) begin
        err_cnt  <= '0;
        err_mask <= '0;
      end
    end
  end

  always_comb begin
    case (sel)
      2'b00:   bus.uo_out = err_cnt[7:0];
      2'b01:   bus.uo_out = err_cnt[15:8];
      2'b10:   bus.uo_out = {locked, 1'b0, seed_cnt, 1'b0, bad_run};
      default: bus.uo_out = err_mask;
    endcase
  end

  assign bus.uio_out = {locked, err_pulse, 6'b0};
  assign bus.uio_oe  = 8'hC0;

endmodule

// File: tb/tb_tt_um_irrationalanalysis_prbs31_checker.sv
// Directed bench for the PRBS31 checker: vector tables plus sequences for
// lock loss, reseeding and error-counter saturation.
module tb_tt_um_irrationalanalysis_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  tt_um_irrationalanalysis_prbs31_checker_if bus ();

  tt_um_irrationalanalysis_prbs31_checker #(.LOSS_RUN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       en;
    logic       clr;
    logic [1:0] sel;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t tab[$];
  bit   mq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(logic [7:0] d, logic v, logic e, logic c,
                              logic [1:0] s, logic [7:0] euo, logic [7:0] euio);
    vec_t r;
    r.data = d; r.valid = v; r.en = e; r.clr = c; r.sel = s;
    r.exp_uo = euo; r.exp_uio = euio;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic v, input logic e,
                       input logic c, input logic [1:0] s);
    bus.ui_in  = d;
    bus.uio_in = {4'b0, c, s, v};
    bus.ena    = e;
    @(negedge clk);
  endtask

  task automatic run_tab(input string tag);
    foreach (tab[i]) begin
      apply(tab[i].data, tab[i].valid, tab[i].en, tab[i].clr, tab[i].sel);
      check($sformatf("%s[%0d].uo", tag, i), bus.uo_out, tab[i].exp_uo);
      check($sformatf("%s[%0d].uio", tag, i), bus.uio_out, tab[i].exp_uio);
    end
    tab.delete();
  endtask

  task automatic do_reset();
    rst_n      = 1'b1;
    bus.ui_in  = '0;
    bus.uio_in = '0;
    bus.ena    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Transmitted-stream model: queue of the last 31 bits, oldest at index 0.
  task automatic model_init_ones();
    mq.delete();
    for (int i = 0; i < 31; i++) mq.push_back(1'b1);
  endtask

  task automatic next_byte(output logic [7:0] b);
    bit nb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      nb = mq[0] ^ mq[3];
      mq.push_back(nb);
      void'(mq.pop_front());
      b = {b[6:0], nb};
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_st;

    bus.ui_in  = '0;
    bus.uio_in = '0;
    bus.ena    = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state, FF x4 seed, 00 x3 clean, ena/valid gating
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 8'h00));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd0, 8'h00, 8'h00));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd1, 8'h00, 8'h00));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd3, 8'h00, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h10, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h20, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h30, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h80, 8'h80));
    tab.push_back(mk(8'h00, 1, 1, 0, 2'd0, 8'h00, 8'h80));
    tab.push_back(mk(8'h00, 1, 1, 0, 2'd3, 8'h00, 8'h80));
    tab.push_back(mk(8'h00, 1, 1, 0, 2'd2, 8'h80, 8'h80));
    tab.push_back(mk(8'h55, 1, 0, 0, 2'd2, 8'h80, 8'h80));
    tab.push_back(mk(8'hAA, 0, 1, 0, 2'd2, 8'h80, 8'h80));
    check("uio_oe", bus.uio_oe, 8'hC0);
    run_tab("seed");

    model_init_ones();
    for (int i = 0; i < 3; i++) next_byte(b);
    for (int i = 0; i < 200; i++) begin
      next_byte(b);
      apply(b, 1, 1, 0, 2'd0);
      check($sformatf("prbs[%0d].pulse", i), bus.uio_out, 8'h80);
    end
    apply(8'h00, 0, 1, 0, 2'd0);
    check("prbs.cnt_lo", bus.uo_out, 8'h00);
    apply(8'h00, 0, 1, 0, 2'd1);
    check("prbs.cnt_hi", bus.uo_out, 8'h00);

    // Mid-stream reset
    do_reset();
    apply(8'h00, 0, 1, 0, 2'd2);
    check("rst_mid.status", bus.uo_out, 8'h00);
    check("rst_mid.uio", bus.uio_out, 8'h00);

    // Single-bit error: 00 01 00 after lock
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h10, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h20, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h30, 8'h00));
    tab.push_back(mk(8'hFF, 1, 1, 0, 2'd2, 8'h80, 8'h80));
    tab.push_back(mk(8'h00, 1, 1, 0, 2'd0, 8'h00, 8'h80));
    tab.push_back(mk(8'h01, 1, 1, 0, 2'd3, 8'h01, 8'hC0));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h81, 8'h80));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd0, 8'h01, 8'h80));
    tab.push_back(mk(8'h00, 1, 1, 0, 2'd2, 8'h80, 8'h80));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd3, 8'h00, 8'h80));
    tab.push_back(mk(8'h00, 0, 1, 0, 2'd0, 8'h01, 8'h80));
    run_tab("single");

    // Four bad bytes drop lock, four clean bytes relock
    model_init_ones();
    for (int i = 0; i < 3; i++) next_byte(b);
    for (int k = 0; k < 4; k++) begin
      next_byte(b);
      apply(b ^ 8'h01, 1, 1, 0, 2'd2);
      exp_st = (k < 3) ? 8'h81 + 8'(k) : 8'h00;
      check($sformatf("loss[%0d].status", k), bus.uo_out, exp_st);
      check($sformatf("loss[%0d].uio", k), bus.uio_out, (k < 3) ? 8'hC0 : 8'h40);
    end
    for (int k = 0; k < 4; k++) begin
      next_byte(b);
      apply(b, 1, 1, 0, 2'd2);
      exp_st = (k < 3) ? 8'((k + 1) << 4) : 8'h80;
      check($sformatf("relock[%0d].status", k), bus.uo_out, exp_st);
      check($sformatf("relock[%0d].uio", k), bus.uio_out, (k < 3) ? 8'h00 : 8'h80);
    end
    for (int k = 0; k < 3; k++) begin
      next_byte(b);
      apply(b, 1, 1, 0, 2'd0);
      check($sformatf("post[%0d].cnt", k), bus.uo_out, 8'h05);
      check($sformatf("post[%0d].uio", k), bus.uio_out, 8'h80);
    end

    // All-zero stream never locks; seed_cnt wraps
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(8'h00, 1, 1, 0, 2'd2);
      check($sformatf("zero[%0d].status", k), bus.uo_out, 8'(((k + 1) % 4) << 4));
      check($sformatf("zero[%0d].uio", k), bus.uio_out, 8'h00);
    end

    // Saturation: rounds of 4 inverted bytes (32 errors) then 4 reseed bytes
    do_reset();
    for (int k = 0; k < 4; k++) apply(8'hFF, 1, 1, 0, 2'd2);
    check("sat.locked", bus.uio_out, 8'h80);
    model_init_ones();
    for (int r = 0; r < 2100; r++) begin
      for (int k = 0; k < 4; k++) begin
        next_byte(b);
        apply(~b, 1, 1, 0, 2'd0);
      end
      for (int k = 0; k < 4; k++) begin
        next_byte(b);
        apply(b, 1, 1, 0, 2'd0);
      end
      if (r == 0) begin
        check("sat.r0_lo", bus.uo_out, 8'h20);
        check("sat.r0_locked", bus.uio_out, 8'h80);
      end
      if (r == 2046) begin
        check("sat.r2046_lo", bus.uo_out, 8'hE0);
        apply(8'h00, 0, 1, 0, 2'd1);
        check("sat.r2046_hi", bus.uo_out, 8'hFF);
      end
      if (r == 2047) check("sat.r2047_lo", bus.uo_out, 8'hFF);
    end
    apply(8'h00, 0, 1, 0, 2'd0);
    check("sat.end_lo", bus.uo_out, 8'hFF);
    apply(8'h00, 0, 1, 0, 2'd1);
    check("sat.end_hi", bus.uo_out, 8'hFF);
    apply(8'h00, 0, 1, 0, 2'd2);
    check("sat.end_status", bus.uo_out, 8'h80);

    // Clear together with a fully corrupted byte
    next_byte(b);
    apply(~b, 1, 1, 1, 2'd0);
    check("clr.cnt_lo", bus.uo_out, 8'h00);
    apply(8'h00, 0, 1, 0, 2'd1);
    check("clr.cnt_hi", bus.uo_out, 8'h00);
    apply(8'h00, 0, 1, 0, 2'd3);
    check("clr.mask", bus.uo_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_um_irrationalanalysis_prbs31_checker.md
# tt_um_irrationalanalysis_prbs31_checker

Receive-side PRBS31 checker (x^31 + x^28 + 1) for the byte-parallel PRBS31 generator tile. It samples one byte per valid cycle, self-seeds from the incoming stream, then locks and predicts each following byte. Every received bit that differs from its prediction is counted. Lock is dropped automatically after a run of corrupted bytes. Status and counters are read out through a byte-select mux on `uo_out`.

## Interface
- `LOSS_RUN`, default 4: consecutive bad bytes that drop lock (range 1..7).
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst_n`  input  1  synchronous, active-high reset (asserted = 1, despite the name).
- `ena`  input  1  tile enable; when low, the block treats every cycle as invalid.
- `ui_in`  input  8  received PRBS byte. `ui_in[7]` is the earliest bit in time; `ui_in[0]` is the latest.
- `uio_in`  input  8  control inputs:
  - [0] `valid`
  - [2:1] readout select
  - [3] `clr_cnt`
  - [7:4] unused
- `uo_out`  output  8  readout byte (see Operation).
- `uio_out`  output  8  status outputs:
  - [7] `locked`
  - [6] `err_pulse`
  - [5:0] = 0
- `uio_oe`  output  8  constant 8'hC0.

## Operation
- Sequence rule: s[n] = s[n-31] ^ s[n-28].
- Internal state:
  - 31-bit history `h`, where h[0] is the newest bit.
  - 2-bit `seed_cnt`.
  - 3-bit `bad_run`.
  - 16-bit `err_cnt`.
  - 8-bit `err_mask`.
  - `locked` flag.
- A byte is accepted when `valid & ena` = 1.
- Prediction: 8 bits are generated serially from `h`, earliest first. Each bit is p = h[30] ^ h[27], which is then shifted into `h`. The resulting predicted byte has its earliest bit in bit 7.
- State SEED (`locked` = 0):
  - Each accepted byte is shifted into `h`, MSB first.
  - `seed_cnt` increments.
  - On the 4th byte, `h` holds the last 31 received bits. If that `h` is non-zero, go to LOCKED. If it is all zero, stay in SEED with `seed_cnt` = 0.
  - `err_cnt` is not updated in SEED.
- State LOCKED (`locked` = 1), per accepted byte:
  - mask = `ui_in` ^ predicted byte.
  - `h` advances with the predicted bits, never the received bits, so errors do not propagate.
  - `err_mask` <= mask.
  - `err_cnt` <= min(`err_cnt` + popcount(mask), 16'hFFFF). The counter saturates at FFFF.
  - If mask != 0: `bad_run` += 1 and `err_pulse` = 1 for the next cycle. Otherwise `bad_run` <= 0.
  - If `bad_run` reaches `LOSS_RUN`: go to SEED with `seed_cnt` = 0 and `bad_run` = 0. `err_cnt` is kept.
- `clr_cnt` = 1 at an edge sets `err_cnt` = 0 and `err_mask` = 0. Clear wins over an error that arrives in the same cycle; that byte's errors are discarded. `bad_run` and lock state are unaffected.
- Readout `uo_out`, combinational from registers, selected by `uio_in[2:1]`:
  - 00: `err_cnt[7:0]`
  - 01: `err_cnt[15:8]`
  - 10: {`locked`, 1'b0, `seed_cnt`[1:0], 1'b0, `bad_run`[2:0]}
  - 11: `err_mask`
- Reset values: `h` = 0, `seed_cnt` = 0, `bad_run` = 0, `err_cnt` = 0, `err_mask` = 0, `locked` = 0, `err_pulse` = 0, `uo_out` = 8'h00 for any select except 10 (which reads 8'h00 too), `uio_out` = 8'h00.

## Timing
- All registers update on the edge that samples an accepted byte. Results are visible on `uo_out` and `uio_out` in the following cycle (1-cycle latency).
- `locked` rises the cycle after the 4th accepted seed byte.
- `locked` falls the cycle after the `LOSS_RUN`-th consecutive bad byte.
- `err_pulse` is high for exactly one cycle per bad byte. Back-to-back bad bytes hold it high continuously.
- Cycles with `valid` = 0 or `ena` = 0 change nothing; `err_pulse` = 0 on those cycles.
- `rst_n` asserted mid-stream: the next cycle shows reset values, and reseeding is required.

## Test plan
- Reset, select = 10 → `uo_out` = 00, `uio_out` = 00, `uio_oe` = C0.
- Feed FF FF FF FF, then 00 00 00 → `locked` = 1 after the 4th byte; `err_cnt` = 0; no `err_pulse`. Then 200 bytes from a PRBS31 model → `err_cnt` stays 0.
- After lock on FF×4, feed 00 01 00 → `err_cnt` = 1, `err_mask` = 01, one `err_pulse`, `bad_run` returns to 0.
- While locked, feed 4 bytes each with bit 0 flipped → `err_cnt` += 4 and `locked` = 0. Then 4 clean bytes → `locked` = 1.
- Feed 00 continuously → `locked` stays 0 and `seed_cnt` wraps.
- Preload to saturation by feeding inverted bytes (8 errors per byte; relocking as needed) until `err_cnt` = FFFF → it holds FFFF. Then assert `clr_cnt` together with a bad byte → `err_cnt` = 0000, `err_mask` = 00.
